// File: rtl/noc_pkg.sv
// Shared types, constants and helpers for the NoC port arbiter family.
package noc_pkg;

    localparam int unsigned FLIT_W   = 9;
    localparam int unsigned TAIL_BIT = 8;

    typedef enum logic [0:0] {
        IDLE,
        LOCKED
    } arb_state_t;

    // Round-robin successor with explicit wrap, safe for non-power-of-two n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, with wrap.
module rr_pick
    import noc_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_any
);

    always_comb begin
        int unsigned idx;
        idx     = 32'(ptr);
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!gnt_any && req[IDXW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDXW'(idx);
            end
            idx = rr_next(idx, N);
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Wormhole N:1 flit arbiter with round-robin grant at packet boundaries.
// Define NOC_PORT_ARBITER_STATS_EN to add per-input saturating tail-flit counters (pkt_count).
module noc_port_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned W    = FLIT_W,
    parameter int unsigned N    = 2,
    parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            _RESET,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    input  logic            out_ready,
    output logic [IDXW-1:0] owner,
    output logic            busy
`ifdef NOC_PORT_ARBITER_STATS_EN
    ,
    output logic [N*16-1:0] pkt_count
`endif
);

    arb_state_t      state_q, state_d;
    logic [IDXW-1:0] rr_ptr_q, owner_q;
    logic [IDXW-1:0] gnt_idx, sel_idx;
    logic            gnt_any, can_load, xfer, sel_tail;
    logic [W-1:0]    sel_flit;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign can_load = !out_valid || out_ready;
    assign sel_idx  = (state_q == LOCKED) ? owner_q : gnt_idx;
    assign xfer     = |(in_valid & in_ready);
    assign sel_tail = sel_flit[W-1];
    assign owner    = owner_q;

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_idx == IDXW'(i)) sel_flit = in_data[i*W +: W];
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (xfer && !sel_tail) state_d = LOCKED;
            LOCKED: if (xfer &&  sel_tail) state_d = IDLE;
        endcase
    end

    // Accept is held off while reset is asserted so no flit is taken into a clearing pipeline.
    always_comb begin
        in_ready = '0;
        if (_RESET && (state_q == LOCKED || gnt_any)) in_ready[sel_idx] = can_load;
        busy = (state_q == LOCKED);
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_flit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && state_q == IDLE && !sel_tail) owner_q <= gnt_idx;
            if (xfer && sel_tail) rr_ptr_q <= IDXW'(rr_next(32'(sel_idx), N));
        end
    end

`ifdef NOC_PORT_ARBITER_STATS_EN
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            pkt_count <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (xfer && sel_tail && sel_idx == IDXW'(i) &&
                    pkt_count[i*16 +: 16] != 16'hFFFF) begin
                    pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Synchronous wormhole arbiter that shares one 9-bit flit output channel between N input channels.
- Sits in front of a decoder8-class routing stage. It merges traffic from several upstream ports into the decoder's single input channel.
- Packets are never interleaved. Grant rotates round-robin at packet boundaries.

Parameters:
- W, 9, flit width. Bit W-1 is the tail flag; bits W-2:0 are payload.
- N, 2, number of requesting input channels (2..8).
- IDXW, $clog2(N) (min 1), width of the grant index.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- _RESET  input  1  asynchronous, active-low reset.
- in_valid  input  N  per-input flit valid.
- in_data  input  N*W  per-input flit. Slice i occupies bits [i*W +: W].
- in_ready  output  N  per-input accept. A flit transfers when in_valid[i] && in_ready[i].
- out_valid  output  1  output register holds a flit.
- out_data  output  W  registered flit.
- out_ready  input  1  downstream accept. A flit transfers when out_valid && out_ready.
- owner  output  IDXW  index of the input currently locked; meaningful while busy=1.
- busy  output  1  a packet is in progress (state LOCKED).

Behaviour:
- Reset (asynchronous, _RESET=0):
  - state=IDLE, rr_ptr=0, owner=0, busy=0, out_valid=0, out_data=0, in_ready=0.
  - Reset mid-packet drops the packet; the downstream flit in flight is discarded.
- Output stage:
  - Single register. can_load = !out_valid || out_ready.
  - A flit accepted in cycle t appears on out_data with out_valid=1 in cycle t+1. Latency is 1 cycle.
  - Full throughput of 1 flit/cycle when out_ready is held at 1.
- State IDLE:
  - Arbitrate combinationally among in_valid. Start at rr_ptr and search upward with wrap (rr_ptr, rr_ptr+1, ..., N-1, 0, ...).
  - The winner g gets in_ready[g]=can_load; all other in_ready are 0.
  - On transfer of a non-tail flit: go to LOCKED, owner=g, busy=1.
  - On transfer of a tail flit (single-flit packet): stay IDLE, rr_ptr=(g+1) mod N.
  - If no input is valid, or can_load=0, nothing changes.
- State LOCKED:
  - in_ready[owner]=can_load; all other in_ready are 0, regardless of their valid.
  - On transfer of a tail flit from owner: go to IDLE, rr_ptr=(owner+1) mod N, busy=0 in the next cycle.
  - Bubbles (in_valid[owner]=0) hold the lock indefinitely.
- Fairness: with all inputs continuously requesting, grants are issued in order 0,1,...,N-1,0 per packet.
- Inputs must hold in_valid/in_data stable until accepted. The arbiter never revokes in_ready[i] while in_valid[i]=1 within one lock.
- A new packet can start in the same cycle the previous tail leaves the output register.
- rr_ptr wrap: at N-1 it goes to 0. Non-power-of-two N uses explicit mod, never a truncated add.

Optional Feature:
- Macro: NOC_PORT_ARBITER_STATS_EN.
- When defined:
  - Adds output pkt_count (N*16): one saturating 16-bit counter per input.
  - A counter increments on acceptance of that input's tail flit and sticks at 0xFFFF.
  - All counters reset to 0 with _RESET.
- When undefined:
  - The port and counters do not exist.
  - Behaviour is otherwise identical.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W=9 and TAIL_BIT=8 constants.
  - arb_state_t enum {IDLE, LOCKED}.
  - Helper function rr_next(idx, n).
- One sub-module: rr_pick. It is a combinational round-robin priority picker (req[N], ptr → gnt_idx, gnt_any) and is reusable by other NoC arbiters.

Test Plan:
- Reset during LOCKED with out_valid=1 → next cycle busy=0, out_valid=0, in_ready=0. After release, input 0 wins first.
- N=2, both inputs send continuous 3-flit packets, out_ready=1:
  - Output order is A0,A1,A2(tail),B0,B1,B2(tail),A0...
  - No interleaving; in_ready[1]=0 throughout the A packet.
- Input 1 sends single tail flits 0x1AA; input 0 is idle:
  - One flit accepted per cycle.
  - rr_ptr toggles to 0 after each flit, yet input 1 still wins every cycle because input 0 is idle.
- Backpressure: out_ready=0 for 4 cycles mid-packet:
  - out_data holds its value, in_ready[owner]=0, and no flit is lost or duplicated.
  - Resumes at 1 flit/cycle.
- Bubble: the owner drops in_valid for 3 cycles mid-packet while input 1 is valid → busy stays 1 and input 1 is not granted until the owner's tail.
- With NOC_PORT_ARBITER_STATS_EN: send 70000 single-flit packets on input 0 → pkt_count[0] saturates at 0xFFFF and pkt_count[1]=0.
